dma_writeback: RTL and testbench
================================

DMA_WRITEBACK -- requirements
Module: dma_writeback

Interface
REQ-001 Parameter IMAGE_SIZE, default 4096, is the pixel count to write; legal values are multiples of 4 and at least 4.
REQ-002 Parameter BASE_ADDR, default 0, is the memory byte address of pixel 0.
REQ-003 clk  in  1  single clock; all logic is clocked on its rising edge.
REQ-004 reset_n  in  1  reset, asynchronous and active-low.
REQ-005 start  in  1  level request; sampled only in IDLE.
REQ-006 busy  out  1  high in every state except IDLE and DONE.
REQ-007 done  out  1  high while in DONE.
REQ-008 fifo_data_k  in  8  pixel from lane FIFO k, for k = 0..3; valid the cycle after fifo_rd_en_k.
REQ-009 fifo_empty_k  in  1  lane FIFO k holds no data, for k = 0..3.
REQ-010 fifo_rd_en_k  out  1  one-cycle pop strobe to lane FIFO k, for k = 0..3.
REQ-011 mem_addr  out  32  write address.
REQ-012 mem_data_out  out  8  write data.
REQ-013 mem_rw  out  1  constant 1 (write).
REQ-014 mem_en  out  1  write request.
REQ-015 mem_ready  in  1  memory accepts the request in the cycle where mem_en && mem_ready.

Function
REQ-016 FSM states: IDLE, POP, CAPTURE, WRITE, DONE.
REQ-017 IDLE -> POP when start=1; pixel counter cnt is cleared to 0 on this transition.
REQ-018 Lane selection: lane = cnt[1:0], so pixel n is taken from FIFO n mod 4 (inverse of the read-side distribution).
REQ-019 POP with fifo_empty_lane=0: assert fifo_rd_en_lane for exactly one cycle, then go to CAPTURE.
REQ-020 POP with fifo_empty_lane=1: stay in POP with no strobe; the other lanes are never popped out of order.
REQ-021 CAPTURE: register fifo_data_lane into mem_data_out and set mem_addr = BASE_ADDR + cnt (32-bit, wraps modulo 2^32), then go to WRITE.
REQ-022 WRITE: hold mem_en=1 with mem_addr and mem_data_out stable until mem_ready=1.
REQ-023 On acceptance with cnt == IMAGE_SIZE-1: go to DONE; otherwise increment cnt and go to POP.
REQ-024 Minimum per-pixel latency is 3 cycles (POP, CAPTURE, one WRITE cycle); the earliest done is 3*IMAGE_SIZE+1 cycles after start is sampled.
REQ-025 DONE: done=1; stay in DONE while start=1; go to IDLE when start=0, so that exactly one frame is written per start assertion.
REQ-026 mem_en is 0 outside WRITE; at most one fifo_rd_en_k is high in any cycle.
REQ-027 A start level change while busy is ignored.
REQ-028 mem_ready asserted outside WRITE has no effect.

Reset
REQ-029 While reset_n=0: state=IDLE, cnt=0, done=0, all fifo_rd_en_k=0, mem_en=0, mem_addr=0, mem_data_out=0.
REQ-030 Reset asserted mid-frame aborts the frame immediately; no further pop or write occurs, and after release the block waits in IDLE for start.

Structure
REQ-031 The state encoding and the lane count (4) are defined in the shared image-thresholding package used by the DMA blocks.
REQ-032 The lane mux with its pop-strobe decode is the one natural sub-module, named dma_lane_sel; everything else is flat.

Verification
REQ-033 IMAGE_SIZE=8, BASE_ADDR=0x100, FIFOs preloaded with lane k holding 0x10*k+n, mem_ready tied 1 -> writes 0x00,0x10,0x20,0x30,0x01,0x11,0x21,0x31 to addresses 0x100..0x107 in order; done rises 25 cycles after start is sampled.
REQ-034 Lane 2 empty for 10 cycles at pixel 2 -> stall in POP with no fifo_rd_en pulses and mem_en=0; the write order is unchanged after the data arrives.
REQ-035 mem_ready held low 5 cycles in WRITE -> mem_en, mem_addr and mem_data_out stay stable for 6 cycles, with one write accepted.
REQ-036 reset_n pulled low during WRITE of pixel 3 -> all outputs are 0 that cycle; a new start rewrites from BASE_ADDR with pixel 0 taken from lane 0.
REQ-037 start held high after done -> no second frame and done stays 1; start dropped -> IDLE next cycle and done=0.
REQ-038 BASE_ADDR=0xFFFFFFFE, IMAGE_SIZE=4 -> addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.

Source files
------------

// File: rtl/dma_writeback_pkg.sv
// Shared definitions for the image-thresholding DMA blocks: lane count, pixel/address
// widths and the write-back state encoding.
package dma_writeback_pkg;

    localparam int unsigned NUM_LANES  = 4;
    localparam int unsigned LANE_IDX_W = 2;
    localparam int unsigned PIX_W      = 8;
    localparam int unsigned ADDR_W     = 32;

    typedef logic [LANE_IDX_W-1:0] lane_idx_t;
    typedef logic [PIX_W-1:0]      pixel_t;
    typedef logic [2:0]            dma_state_t;

    localparam dma_state_t ST_IDLE    = 3'd0;
    localparam dma_state_t ST_POP     = 3'd1;
    localparam dma_state_t ST_CAPTURE = 3'd2;
    localparam dma_state_t ST_WRITE   = 3'd3;
    localparam dma_state_t ST_DONE    = 3'd4;

    function automatic logic [NUM_LANES-1:0] lane_decode(input lane_idx_t lane);
        logic [NUM_LANES-1:0] onehot;
        onehot       = '0;
        onehot[lane] = 1'b1;
        return onehot;
    endfunction

endpackage

// File: rtl/dma_lane_sel.sv
// Lane multiplexer: selects the current lane's FIFO data/empty flag and decodes the
// single pop strobe for that lane.
module dma_lane_sel
    import dma_writeback_pkg::*;
(
    input  logic                   pop_req,
    input  lane_idx_t              lane,
    input  logic [NUM_LANES-1:0]   fifo_empty,
    input  pixel_t [NUM_LANES-1:0] fifo_data,
    output logic                   lane_empty,
    output pixel_t                 lane_data,
    output logic [NUM_LANES-1:0]   fifo_rd_en
);

    always_comb begin
        lane_empty = fifo_empty[lane];
        lane_data  = fifo_data[lane];
        fifo_rd_en = '0;
        // Never pop an empty lane; other lanes wait their turn.
        if (pop_req && !lane_empty) begin
            fifo_rd_en = lane_decode(lane);
        end
    end

endmodule

// File: rtl/dma_writeback.sv
// Drains four lane FIFOs in round-robin pixel order and writes each pixel to memory at
// BASE_ADDR + pixel index, one frame per start request.
module dma_writeback
    import dma_writeback_pkg::*;
#(
    parameter int unsigned IMAGE_SIZE = 4096,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    input  logic [7:0]  fifo_data_0,
    input  logic [7:0]  fifo_data_1,
    input  logic [7:0]  fifo_data_2,
    input  logic [7:0]  fifo_data_3,
    input  logic        fifo_empty_0,
    input  logic        fifo_empty_1,
    input  logic        fifo_empty_2,
    input  logic        fifo_empty_3,
    output logic        fifo_rd_en_0,
    output logic        fifo_rd_en_1,
    output logic        fifo_rd_en_2,
    output logic        fifo_rd_en_3,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_data_out,
    output logic        mem_rw,
    output logic        mem_en,
    input  logic        mem_ready
);

    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(IMAGE_SIZE - 1);

    dma_state_t           state_q, state_d;
    logic [ADDR_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    pixel_t               data_q, data_d;

    logic                 pop_req;
    logic                 lane_empty;
    pixel_t               lane_data;
    lane_idx_t            lane;
    logic [NUM_LANES-1:0] rd_en;

    // Pixel n lives in lane n mod 4, mirroring the read-side distribution.
    assign lane    = cnt_q[LANE_IDX_W-1:0];
    assign pop_req = (state_q == ST_POP);

    dma_lane_sel u_lane_sel (
        .pop_req    (pop_req),
        .lane       (lane),
        .fifo_empty ({fifo_empty_3, fifo_empty_2, fifo_empty_1, fifo_empty_0}),
        .fifo_data  ({fifo_data_3, fifo_data_2, fifo_data_1, fifo_data_0}),
        .lane_empty (lane_empty),
        .lane_data  (lane_data),
        .fifo_rd_en (rd_en)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_POP;
                    cnt_d   = '0;
                end
            end
            ST_POP: begin
                if (!lane_empty) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                // FIFO data is valid the cycle after the pop strobe.
                data_d  = lane_data;
                addr_d  = BASE_ADDR + cnt_q;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (mem_ready) begin
                    if (cnt_q == LAST_PIX) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = ST_POP;
                    end
                end
            end
            ST_DONE: begin
                // Wait for start to drop so one request yields exactly one frame.
                if (!start) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign busy         = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done         = (state_q == ST_DONE);
    assign mem_en       = (state_q == ST_WRITE);
    assign mem_rw       = 1'b1;
    assign mem_addr     = addr_q;
    assign mem_data_out = data_q;
    assign fifo_rd_en_0 = rd_en[0];
    assign fifo_rd_en_1 = rd_en[1];
    assign fifo_rd_en_2 = rd_en[2];
    assign fifo_rd_en_3 = rd_en[3];

    rd_en_onehot_a: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(rd_en));

    write_hold_a: assert property (@(posedge clk) disable iff (!reset_n)
        (mem_en && !mem_ready) |=> (mem_en && $stable(mem_addr) && $stable(mem_data_out)));

endmodule

// File: tb/tb_dma_writeback.sv
// Scoreboard bench for dma_writeback: expected writes are queued by the stimulus and a
// monitor pops and compares them on every accepted memory write.
module tb_dma_writeback;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        start;
    logic        mem_ready;
    logic [7:0]  fd [4] = '{default: 8'h00};
    logic [3:0]  fe = 4'hF;
    logic [3:0]  rd;
    logic        busy, done, mem_rw, mem_en;
    logic [31:0] mem_addr;
    logic [7:0]  mem_data;

    logic        b_start;
    logic        b_busy, b_done, b_rw, b_en;
    logic [3:0]  b_rd;
    logic [31:0] b_addr;
    logic [7:0]  b_data;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] lane_q [4][$];
    wr_t        exp_q[$];
    wr_t        b_exp[$];

    dma_writeback #(
        .IMAGE_SIZE (8),
        .BASE_ADDR  (32'h0000_0100)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .fifo_data_0  (fd[0]),
        .fifo_data_1  (fd[1]),
        .fifo_data_2  (fd[2]),
        .fifo_data_3  (fd[3]),
        .fifo_empty_0 (fe[0]),
        .fifo_empty_1 (fe[1]),
        .fifo_empty_2 (fe[2]),
        .fifo_empty_3 (fe[3]),
        .fifo_rd_en_0 (rd[0]),
        .fifo_rd_en_1 (rd[1]),
        .fifo_rd_en_2 (rd[2]),
        .fifo_rd_en_3 (rd[3]),
        .mem_addr     (mem_addr),
        .mem_data_out (mem_data),
        .mem_rw       (mem_rw),
        .mem_en       (mem_en),
        .mem_ready    (mem_ready)
    );

    dma_writeback #(
        .IMAGE_SIZE (4),
        .BASE_ADDR  (32'hFFFF_FFFE)
    ) dut_b (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (b_start),
        .busy         (b_busy),
        .done         (b_done),
        .fifo_data_0  (8'hA0),
        .fifo_data_1  (8'hA1),
        .fifo_data_2  (8'hA2),
        .fifo_data_3  (8'hA3),
        .fifo_empty_0 (1'b0),
        .fifo_empty_1 (1'b0),
        .fifo_empty_2 (1'b0),
        .fifo_empty_3 (1'b0),
        .fifo_rd_en_0 (b_rd[0]),
        .fifo_rd_en_1 (b_rd[1]),
        .fifo_rd_en_2 (b_rd[2]),
        .fifo_rd_en_3 (b_rd[3]),
        .mem_addr     (b_addr),
        .mem_data_out (b_data),
        .mem_rw       (b_rw),
        .mem_en       (b_en),
        .mem_ready    (1'b1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Lane FIFO model: pop on strobe, data presented the following cycle.
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rd[k]) begin
                if (lane_q[k].size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL pop_empty_lane%0d: got pop strobe, expected none", k);
                end else begin
                    fd[k] <= lane_q[k].pop_front();
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            fe[k] = (lane_q[k].size() == 0);
        end
    end

    // Monitor for the main instance.
    always @(negedge clk) begin
        if (reset_n) begin
            if (rd != 4'b0000) begin
                n_cmp++;
                if ($countones(rd) > 1) begin
                    n_fail++;
                    $display("FAIL rd_en_onehot: got %b, expected at most one strobe", rd);
                end
            end
            if (mem_rw !== 1'b1) begin
                n_fail++;
                $display("FAIL mem_rw: got %b, expected 1", mem_rw);
            end
            if (mem_en && mem_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none",
                             mem_addr, mem_data);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    if (mem_addr !== e.addr || mem_data !== e.data) begin
                        n_fail++;
                        $display("FAIL write: got addr 0x%0h data 0x%0h, expected addr 0x%0h data 0x%0h",
                                 mem_addr, mem_data, e.addr, e.data);
                    end
                end
            end
        end
    end

    // Monitor for the address-wrap instance (memory always ready).
    always @(negedge clk) begin
        if (reset_n) begin
            if ($countones(b_rd) > 1 || b_rw !== 1'b1) begin
                n_cmp++;
                n_fail++;
                $display("FAIL b_protocol: got rd %b rw %b, expected onehot0 and rw 1", b_rd, b_rw);
            end
            if (b_en) begin
                n_cmp++;
                if (b_exp.size() == 0) begin
                    n_fail++;
                    $display("FAIL b_unexpected_write: got addr 0x%0h, expected none", b_addr);
                end else begin
                    wr_t e;
                    e = b_exp.pop_front();
                    if (b_addr !== e.addr || b_data !== e.data) begin
                        n_fail++;
                        $display("FAIL b_write: got addr 0x%0h data 0x%0h, expected addr 0x%0h data 0x%0h",
                                 b_addr, b_data, e.addr, e.data);
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load_lanes(input logic [7:0] base, input logic [3:0] mask);
        for (int n = 0; n < 2; n++) begin
            for (int k = 0; k < 4; k++) begin
                if (mask[k]) lane_q[k].push_back(base + 8'(16 * k + n));
            end
        end
    endtask

    task automatic load_exp(input logic [7:0] base, input int npix);
        wr_t w;
        for (int p = 0; p < npix; p++) begin
            w.addr = 32'h100 + 32'(p);
            w.data = base + 8'(16 * (p % 4) + p / 4);
            exp_q.push_back(w);
        end
    endtask

    task automatic wait_done(input string name, output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < 200) begin
            cyc();
            cycles++;
        end
        chk1(name, done, 1'b1);
    endtask

    task automatic finish_frame(input string name);
        int c;
        wait_done(name, c);
        start = 1'b0;
        cyc();
        chk1({name, "_done_clear"}, done, 1'b0);
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int          c;
        int          bad;
        logic [31:0] a0;
        logic [7:0]  d0;
        wr_t         w;

        reset_n   = 1'b0;
        start     = 1'b0;
        b_start   = 1'b0;
        mem_ready = 1'b1;
        repeat (3) cyc();

        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk("rst_rd_en", 32'(rd), 32'd0);
        chk1("rst_mem_en", mem_en, 1'b0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_data", 32'(mem_data), 32'd0);
        chk1("rst_b_busy", b_busy, 1'b0);
        reset_n = 1'b1;
        repeat (2) cyc();

        // Basic frame, done latency, then start held high after done.
        load_lanes(8'h00, 4'b1111);
        load_exp(8'h00, 8);
        start = 1'b1;
        wait_done("frame1_done", c);
        chk("frame1_latency", 32'(c), 32'd25);
        bad = 0;
        repeat (6) begin
            cyc();
            if (done !== 1'b1 || busy !== 1'b0 || rd !== 4'b0000) bad++;
        end
        chk("hold_start_done", 32'(bad), 32'd0);
        start = 1'b0;
        cyc();
        chk1("drop_start_done", done, 1'b0);
        chk1("drop_start_busy", busy, 1'b0);
        chk("frame1_all_written", 32'(exp_q.size()), 32'd0);

        // Address wrap at the top of the 32-bit space.
        for (int p = 0; p < 4; p++) begin
            w.addr = 32'hFFFF_FFFE + 32'(p);
            w.data = 8'hA0 + 8'(p);
            b_exp.push_back(w);
        end
        b_start = 1'b1;
        c = 0;
        while (b_done !== 1'b1 && c < 60) begin
            cyc();
            c++;
        end
        chk1("wrap_done", b_done, 1'b1);
        chk("wrap_latency", 32'(c), 32'd13);
        b_start = 1'b0;
        cyc();
        chk1("wrap_done_clear", b_done, 1'b0);
        chk("wrap_all_written", 32'(b_exp.size()), 32'd0);

        // Lane 2 empty when pixel 2 comes up; start dropped while busy is ignored.
        load_lanes(8'h40, 4'b1011);
        load_exp(8'h40, 8);
        start = 1'b1;
        repeat (7) cyc();
        start = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (rd !== 4'b0000 || mem_en !== 1'b0 || busy !== 1'b1) bad++;
            cyc();
        end
        chk("stall_quiet", 32'(bad), 32'd0);
        chk("stall_pending", 32'(exp_q.size()), 32'd6);
        lane_q[2].push_back(8'h60);
        lane_q[2].push_back(8'h61);
        finish_frame("stall_frame");

        // Memory not ready for 5 cycles on the first write.
        load_lanes(8'h60, 4'b1111);
        load_exp(8'h60, 8);
        mem_ready = 1'b0;
        start     = 1'b1;
        c = 0;
        while (mem_en !== 1'b1 && c < 20) begin
            cyc();
            c++;
        end
        chk1("backpressure_mem_en", mem_en, 1'b1);
        a0 = mem_addr;
        d0 = mem_data;
        chk("backpressure_addr", a0, 32'h100);
        chk("backpressure_data", 32'(d0), 32'h60);
        bad = 0;
        for (int i = 1; i <= 5; i++) begin
            cyc();
            if (mem_en !== 1'b1 || mem_addr !== a0 || mem_data !== d0) bad++;
            if (i == 5) mem_ready = 1'b1;
        end
        chk("backpressure_stable", 32'(bad), 32'd0);
        cyc();
        chk1("backpressure_single_accept", mem_en, 1'b0);
        finish_frame("backpressure_frame");

        // Reset during the write of pixel 3, then a fresh frame.
        load_lanes(8'h70, 4'b1111);
        load_exp(8'h70, 3);
        start = 1'b1;
        c = 0;
        while (!(mem_en === 1'b1 && mem_addr === 32'h103) && c < 40) begin
            cyc();
            c++;
        end
        chk("abort_reached_px3", mem_addr, 32'h103);
        reset_n = 1'b0;
        #1;
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_done", done, 1'b0);
        chk("abort_rd_en", 32'(rd), 32'd0);
        chk1("abort_mem_en", mem_en, 1'b0);
        chk("abort_addr", mem_addr, 32'd0);
        chk("abort_data", 32'(mem_data), 32'd0);
        for (int k = 0; k < 4; k++) lane_q[k].delete();
        start = 1'b0;
        repeat (2) cyc();
        chk("abort_prior_written", 32'(exp_q.size()), 32'd0);
        reset_n = 1'b1;
        repeat (3) cyc();
        chk1("post_abort_idle", busy, 1'b0);
        load_lanes(8'h90, 4'b1111);
        load_exp(8'h90, 8);
        start = 1'b1;
        finish_frame("restart_frame");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: got no finish, expected run to complete");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
